// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with arbitrary depth, programmable
// almost-full/almost-empty thresholds, an occupancy count and a selectable
// first-word-fall-through read mode.
//
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   data_in, wr_en  - write data and write request
//   rd_en           - read request (pop acknowledge in FWFT mode)
//   data_out        - read data (registered, or fall-through when FWFT=1)
//   rd_valid        - data_out holds valid read data
//   wr_ack          - previous-cycle write accepted (SUCCESS) or not (FAILED)
//   overflow        - previous-cycle write rejected because full
//   underflow       - previous-cycle read rejected because empty
//   full, empty, almostfull, almostempty - decoded from count
//   count           - current occupancy
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [FIFO_WIDTH-1:0]              data_in,
    input  logic                               wr_en,
    input  logic                               rd_en,
    output logic [FIFO_WIDTH-1:0]              data_out,
    output logic                               rd_valid,
    output logic                               wr_ack,
    output logic                               overflow,
    output logic                               underflow,
    output logic                               full,
    output logic                               empty,
    output logic                               almostfull,
    output logic                               almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic SUCCESS = 1'b1;
    localparam logic FAILED  = 1'b0;

    localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_r;
    logic                  wr_acc;
    logic                  rd_acc;

    assign count       = count_r;
    assign full        = (count_r == CW'(FIFO_DEPTH));
    assign empty       = (count_r == '0);
    assign almostfull  = (count_r >= CW'(AF_THRESH));
    assign almostempty = (count_r <= CW'(AE_THRESH));

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Storage has no reset; stale contents are never observable because
    // reads are gated by count.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_r   <= '0;
            wr_ack    <= FAILED;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Explicit wrap so non-power-of-two depths work.
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            wr_ack    <= wr_acc ? SUCCESS : FAILED;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head entry is presented directly; zero while empty so reset and
        // drained states show a clean bus.
        assign data_out = empty ? '0 : mem[rd_ptr];
        assign rd_valid = !empty;
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] dout_r;
        logic                  rd_valid_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_r     <= '0;
                rd_valid_r <= 1'b0;
            end else begin
                if (rd_acc) begin
                    dout_r <= mem[rd_ptr];
                end
                rd_valid_r <= rd_acc;
            end
        end

        assign data_out = dout_r;
        assign rd_valid = rd_valid_r;
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: three instances (depth 8 standard,
// depth 5 with custom thresholds, depth 8 FWFT) share clock and reset.
// Read data of the standard-mode instances goes through per-instance
// expectation queues consumed by monitors on rd_valid.
module tb_sync_fifo_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    int total = 0;
    int bad   = 0;

    // Instance A: depth 8, standard read, default thresholds (AF=7, AE=1)
    logic [15:0] a_data_in, a_data_out;
    logic        a_wr_en, a_rd_en, a_rd_valid, a_wr_ack, a_overflow, a_underflow;
    logic        a_full, a_empty, a_af, a_ae;
    logic [3:0]  a_count;

    // Instance B: depth 5, AF=4, AE=2, standard read
    logic [15:0] b_data_in, b_data_out;
    logic        b_wr_en, b_rd_en, b_rd_valid, b_wr_ack, b_overflow, b_underflow;
    logic        b_full, b_empty, b_af, b_ae;
    logic [2:0]  b_count;

    // Instance C: depth 8, FWFT
    logic [15:0] c_data_in, c_data_out;
    logic        c_wr_en, c_rd_en, c_rd_valid, c_wr_ack, c_overflow, c_underflow;
    logic        c_full, c_empty, c_af, c_ae;
    logic [3:0]  c_count;

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .data_in(a_data_in), .wr_en(a_wr_en), .rd_en(a_rd_en),
        .data_out(a_data_out), .rd_valid(a_rd_valid), .wr_ack(a_wr_ack),
        .overflow(a_overflow), .underflow(a_underflow), .full(a_full), .empty(a_empty),
        .almostfull(a_af), .almostempty(a_ae), .count(a_count)
    );

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(2), .FWFT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(b_data_in), .wr_en(b_wr_en), .rd_en(b_rd_en),
        .data_out(b_data_out), .rd_valid(b_rd_valid), .wr_ack(b_wr_ack),
        .overflow(b_overflow), .underflow(b_underflow), .full(b_full), .empty(b_empty),
        .almostfull(b_af), .almostempty(b_ae), .count(b_count)
    );

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .data_in(c_data_in), .wr_en(c_wr_en), .rd_en(c_rd_en),
        .data_out(c_data_out), .rd_valid(c_rd_valid), .wr_ack(c_wr_ack),
        .overflow(c_overflow), .underflow(c_underflow), .full(c_full), .empty(c_empty),
        .almostfull(c_af), .almostempty(c_ae), .count(c_count)
    );

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge and cleared after
    // the next one, so each call is exactly one request cycle.
    task automatic op_a(input logic w, input logic r, input logic [15:0] d);
        a_wr_en = w; a_rd_en = r; a_data_in = d;
        @(posedge clk); #1;
        a_wr_en = 1'b0; a_rd_en = 1'b0;
    endtask

    task automatic op_b(input logic w, input logic r, input logic [15:0] d);
        b_wr_en = w; b_rd_en = r; b_data_in = d;
        @(posedge clk); #1;
        b_wr_en = 1'b0; b_rd_en = 1'b0;
    endtask

    task automatic op_c(input logic w, input logic r, input logic [15:0] d);
        c_wr_en = w; c_rd_en = r; c_data_in = d;
        @(posedge clk); #1;
        c_wr_en = 1'b0; c_rd_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && a_rd_valid) begin
            if (exp_a.size() == 0) begin
                total++; bad++;
                $display("FAIL mon_a: unexpected rd_valid data_out=0x%0h want=no read", a_data_out);
            end else begin
                chk("mon_a_data", a_data_out, exp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_rd_valid) begin
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL mon_b: unexpected rd_valid data_out=0x%0h want=no read", b_data_out);
            end else begin
                chk("mon_b_data", b_data_out, exp_b.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_wr_en = 0; a_rd_en = 0; a_data_in = '0;
        b_wr_en = 0; b_rd_en = 0; b_data_in = '0;
        c_wr_en = 0; c_rd_en = 0; c_data_in = '0;
        #1;
        chk("rst_count", a_count, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_ae", a_ae, 1);
        chk("rst_af", a_af, 0);
        chk("rst_dout", a_data_out, 0);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_wr_ack", a_wr_ack, 0);
        chk("rst_overflow", a_overflow, 0);
        chk("rst_underflow", a_underflow, 0);
        chk("rst_c_rd_valid", c_rd_valid, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // ---- A: fill to full, then overflow ----
        for (int i = 1; i <= 8; i++) begin
            op_a(1'b1, 1'b0, 16'(i));
            chk("fill_count", a_count, i);
            chk("fill_wr_ack", a_wr_ack, 1);
            chk("fill_af", a_af, (i >= 7) ? 1 : 0);
            chk("fill_full", a_full, (i == 8) ? 1 : 0);
            chk("fill_ae", a_ae, (i <= 1) ? 1 : 0);
        end
        op_a(1'b1, 1'b0, 16'hFFFF);
        chk("ovf_flag", a_overflow, 1);
        chk("ovf_wr_ack", a_wr_ack, 0);
        chk("ovf_count", a_count, 8);
        op_a(1'b0, 1'b0, '0);
        chk("ovf_pulse_clear", a_overflow, 0);

        // ---- A: drain in order, then underflow ----
        for (int i = 1; i <= 8; i++) begin
            exp_a.push_back(16'(i));
            op_a(1'b0, 1'b1, '0);
            chk("drain_count", a_count, 8 - i);
            chk("drain_rd_valid", a_rd_valid, 1);
            chk("drain_ae", a_ae, ((8 - i) <= 1) ? 1 : 0);
        end
        op_a(1'b0, 1'b1, '0);
        chk("udf_flag", a_underflow, 1);
        chk("udf_empty", a_empty, 1);
        chk("udf_rd_valid", a_rd_valid, 0);
        chk("udf_dout_hold", a_data_out, 16'h0008);

        // ---- A: simultaneous access ----
        op_a(1'b1, 1'b1, 16'h0011);
        chk("sim_empty_count", a_count, 1);
        chk("sim_empty_udf", a_underflow, 1);
        chk("sim_empty_ack", a_wr_ack, 1);
        op_a(1'b1, 1'b0, 16'h0012);
        op_a(1'b1, 1'b0, 16'h0013);
        chk("sim_mid_pre", a_count, 3);
        exp_a.push_back(16'h0011);
        op_a(1'b1, 1'b1, 16'h0014);
        chk("sim_mid_count", a_count, 3);
        chk("sim_mid_ack", a_wr_ack, 1);
        for (int i = 0; i < 5; i++) op_a(1'b1, 1'b0, 16'(16'h0015 + i));
        chk("sim_full_pre", a_full, 1);
        exp_a.push_back(16'h0012);
        op_a(1'b1, 1'b1, 16'hBEEF);
        chk("sim_full_count", a_count, 7);
        chk("sim_full_ovf", a_overflow, 1);
        chk("sim_full_ack", a_wr_ack, 0);

        // ---- B: depth 5, thresholds and wrap ----
        for (int i = 0; i < 3; i++) begin
            op_b(1'b1, 1'b0, 16'(16'h0100 + i));
            chk("b_pre_count", b_count, i + 1);
            chk("b_pre_ae", b_ae, (i + 1 <= 2) ? 1 : 0);
            chk("b_pre_af", b_af, 0);
        end
        for (int k = 0; k < 12; k++) begin
            op_b(1'b1, 1'b0, 16'(16'h0103 + k));
            chk("b_w_count", b_count, 4);
            chk("b_w_af", b_af, 1);
            chk("b_w_ae", b_ae, 0);
            exp_b.push_back(16'(16'h0100 + k));
            op_b(1'b0, 1'b1, '0);
            chk("b_r_count", b_count, 3);
            chk("b_r_af", b_af, 0);
            chk("b_r_ae", b_ae, 0);
        end
        for (int j = 0; j < 3; j++) begin
            exp_b.push_back(16'(16'h010C + j));
            op_b(1'b0, 1'b1, '0);
            chk("b_drain_count", b_count, 2 - j);
            chk("b_drain_ae", b_ae, 1);
        end
        chk("b_empty", b_empty, 1);

        // ---- C: first-word-fall-through ----
        op_c(1'b1, 1'b0, 16'hA5A5);
        chk("c_dout", c_data_out, 16'hA5A5);
        chk("c_rd_valid", c_rd_valid, 1);
        chk("c_empty", c_empty, 0);
        op_c(1'b0, 1'b0, '0);
        chk("c_dout_hold", c_data_out, 16'hA5A5);
        op_c(1'b0, 1'b1, '0);
        chk("c_pop_empty", c_empty, 1);
        chk("c_pop_rd_valid", c_rd_valid, 0);
        op_c(1'b1, 1'b0, 16'h1111);
        op_c(1'b1, 1'b0, 16'h2222);
        chk("c_head1", c_data_out, 16'h1111);
        chk("c_count2", c_count, 2);
        op_c(1'b0, 1'b1, '0);
        chk("c_head2", c_data_out, 16'h2222);
        op_c(1'b0, 1'b1, '0);
        chk("c_drained", c_empty, 1);

        // ---- A: asynchronous reset between edges ----
        op_a(1'b1, 1'b0, 16'h001A);
        chk("pre_rst_count", a_count, 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", a_count, 0);
        chk("arst_empty", a_empty, 1);
        chk("arst_dout", a_data_out, 0);
        chk("arst_rd_valid", a_rd_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op_a(1'b0, 1'b1, '0);
        chk("post_rst_udf", a_underflow, 1);
        chk("post_rst_count", a_count, 0);
        op_a(1'b1, 1'b0, 16'h0077);
        exp_a.push_back(16'h0077);
        op_a(1'b0, 1'b1, '0);
        op_a(1'b0, 1'b0, '0);
        op_a(1'b0, 1'b0, '0);

        chk("sb_a_drained", exp_a.size(), 0);
        chk("sb_b_drained", exp_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Parametrised synchronous FIFO, next generation of the team's single-clock FIFO. It adds the following over the previous block:
- arbitrary (non-power-of-two) depth;
- programmable almost-full/almost-empty thresholds;
- an occupancy count output;
- a selectable first-word-fall-through (FWFT) read mode.

It is a drop-in buffer between producer and consumer stages in the same clock domain. Its status outputs have the same meaning as before, so existing scoreboards keep working.

## Interface
- FIFO_WIDTH, 16, data width in bits (>=1)
- FIFO_DEPTH, 8, number of entries (>=2, any integer)
- AF_THRESH, FIFO_DEPTH-1, almostfull asserts when count >= AF_THRESH (1..FIFO_DEPTH)
- AE_THRESH, 1, almostempty asserts when count <= AE_THRESH (0..FIFO_DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- data_in  in  FIFO_WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request (pop in FWFT mode)
- data_out  out  FIFO_WIDTH  read data
- rd_valid  out  1  data_out holds valid read data
- wr_ack  out  1  registered: previous-cycle write accepted (SUCCESS/FAILED from shared_pkg)
- overflow  out  1  registered: previous-cycle write rejected because full
- underflow  out  1  registered: previous-cycle read rejected because empty
- full, empty, almostfull, almostempty  out  1  combinational from count
- count  out  $clog2(FIFO_DEPTH+1)  current occupancy

## Operation
- **Storage and pointers**
  - Storage is a FIFO_DEPTH x FIFO_WIDTH register array.
  - Write and read pointers are $clog2(FIFO_DEPTH) bits. Each wraps from FIFO_DEPTH-1 to 0 by explicit compare, not natural rollover.
  - count is held in a separate register.
- **Write accept:** a write is accepted iff wr_en && !full. An accepted write stores data_in at the write pointer and advances it.
- **Read accept:** a read is accepted iff rd_en && !empty. An accepted read advances the read pointer.
- **Simultaneous wr_en and rd_en**
  - Not full and not empty: both are accepted and count is unchanged.
  - Full: the read is accepted and the write is rejected (overflow=1). Count goes to FIFO_DEPTH-1.
  - Empty: the write is accepted and the read is rejected (underflow=1). Count goes to 1.
- **count update:** count +1 on write only, -1 on read only. count never exceeds FIFO_DEPTH and never goes below 0.
- **Flags**
  - full = (count==FIFO_DEPTH)
  - empty = (count==0)
  - almostfull = (count>=AF_THRESH)
  - almostempty = (count<=AE_THRESH)
- **Standard mode (FWFT=0)**
  - On an accepted read, data_out is registered with the entry at the read pointer.
  - rd_valid pulses high for one cycle after each accepted read.
  - data_out holds its value when no read is accepted.
- **FWFT mode (FWFT=1)**
  - data_out always presents the entry at the read pointer.
  - rd_valid = !empty.
  - rd_en acts as an acknowledge that pops the presented word.
  - data_out is don't-care while empty.
- **Status pulses:** wr_ack, overflow and underflow are single-cycle registered pulses, updated every cycle from that cycle's request outcome.

## Timing
- **Reset (rst_n low, asynchronous)**
  - Pointers and count go to 0.
  - data_out=0, rd_valid=0, wr_ack=FAILED, overflow=0, underflow=0.
  - empty=1, full=0, almostempty=1, almostfull=0.
  - Array contents are not reset.
- **Reset mid-operation:** all buffered data is discarded. The first edge after rst_n deasserts behaves as from an empty FIFO.
- **Write latency:** a write accepted at edge N makes the word readable from edge N.
  - FWFT=1: the word is visible on data_out after edge N, with rd_valid=1.
  - FWFT=0: the earliest read request is in the cycle after N, and the data appears after that read edge.
- **Read latency, FWFT=0:** rd_en sampled at edge N gives data_out and rd_valid valid after edge N, for one cycle for rd_valid.
- **Flag/count timing:** flags and count reflect state after the most recent edge, with no extra pipeline stage.
- **Wrap-around:** with FIFO_DEPTH=5, pointers go 3, 4, 0, 1. Data order is preserved across wrap.
- **Pulse timing:** wr_ack, overflow and underflow are asserted in the cycle following the request edge and deassert next cycle unless re-triggered.

## Test plan
- **Reset and fill, FIFO_DEPTH=8, FWFT=0**
  - Stimulus: reset, then 8 writes of 0x0001..0x0008, then a 9th write of 0xFFFF.
  - count=8, full=1, almostfull=1 from count 7.
  - The 9th write gives overflow=1 and wr_ack=FAILED, and count stays 8.
- **Drain, FIFO_DEPTH=8, FWFT=0**
  - Stimulus: 8 reads, then a 9th read.
  - data_out is 0x0001..0x0008 in order, each with a one-cycle rd_valid, and almostempty=1 at count<=1.
  - The 9th read gives underflow=1, empty=1, and data_out holds 0x0008.
- **Non-power-of-two wrap, FIFO_DEPTH=5, AF_THRESH=4, AE_THRESH=2**
  - Stimulus: 12 interleaved write/read pairs of ascending data.
  - Read order matches write order across wrap.
  - almostfull toggles exactly at count 4, almostempty exactly at count<=2.
- **Simultaneous access**
  - When full: a read is accepted and the write rejected, so count goes 8->7 and overflow=1.
  - When empty: the write is accepted and the read rejected, so count goes 0->1 and underflow=1.
  - At count=3: both are accepted, count stays 3 and wr_ack=SUCCESS.
- **FWFT=1**
  - Write 0xA5A5 into the empty FIFO: next cycle data_out=0xA5A5 and rd_valid=1 with no rd_en.
  - Assert rd_en: next cycle empty=1 and rd_valid=0.
- **Asynchronous reset mid-stream**
  - Stimulus: write 4 words, then pulse rst_n low between clock edges.
  - count=0, empty=1 and data_out=0 immediately, with no clock edge needed.
  - A subsequent read gives underflow=1.
